// File: rtl/checkers_pkg.sv
// Shared types, board constants and diagonal-step helpers for the checkers move enumerator.
// Square index: row = idx[4:2], column slot k = idx[1:0], row parity = idx[2].
package checkers_pkg;
   localparam int BOARD_W   = 32;
   localparam int IDX_W     = 5;
   localparam int CNT_W     = 6;
   localparam int MAX_MOVES = 48;

   typedef enum logic [1:0] {DIR_DR = 2'd0, DIR_DL = 2'd1, DIR_UR = 2'd2, DIR_UL = 2'd3} dir_t;
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CALC  = 3'd1,
      ST_CALC2 = 3'd2,
      ST_EMIT  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Index offset of one diagonal step, chosen by the parity of the row being left.
   function automatic logic signed [IDX_W:0] dir_offset(input dir_t dir, input logic odd_row);
      logic signed [IDX_W:0] off;
      case (dir)
         DIR_DR:  off = odd_row ?  6'sd5 :  6'sd4;
         DIR_DL:  off = odd_row ?  6'sd4 :  6'sd3;
         DIR_UR:  off = odd_row ? -6'sd3 : -6'sd4;
         default: off = odd_row ? -6'sd4 : -6'sd5;
      endcase
      return off;
   endfunction

   function automatic logic step_legal(input logic [IDX_W-1:0] idx, input dir_t dir);
      logic ok;
      ok = 1'b1;
      if ((dir == DIR_DR || dir == DIR_DL) && idx[4:2] == 3'd7) ok = 1'b0;
      if ((dir == DIR_UR || dir == DIR_UL) && idx[4:2] == 3'd0) ok = 1'b0;
      if (!idx[2] && idx[1:0] == 2'd0 && (dir == DIR_DL || dir == DIR_UL)) ok = 1'b0;
      if ( idx[2] && idx[1:0] == 2'd3 && (dir == DIR_DR || dir == DIR_UR)) ok = 1'b0;
      return ok;
   endfunction

   function automatic logic [IDX_W-1:0] step_dst(input logic [IDX_W-1:0] src, input dir_t dir);
      logic signed [IDX_W:0] s;
      s = $signed({1'b0, src}) + dir_offset(dir, src[2]);
      return s[IDX_W-1:0];
   endfunction

   // Inverse step: the source square sits on the row of opposite parity to the destination.
   function automatic logic [IDX_W-1:0] step_src(input logic [IDX_W-1:0] dst, input dir_t dir);
      logic signed [IDX_W:0] s;
      s = $signed({1'b0, dst}) - dir_offset(dir, ~dst[2]);
      return s[IDX_W-1:0];
   endfunction
endpackage

// File: rtl/board_diag_shift.sv
// One combinational diagonal board shift: every set square moves one step in DIR;
// pieces that would leave the board are dropped.
module board_diag_shift
   import checkers_pkg::*;
#(
   parameter dir_t DIR = DIR_DR
) (
   input  logic [BOARD_W-1:0] i_src,
   output logic [BOARD_W-1:0] o_dst
);
   always_comb begin
      o_dst = '0;
      for (int s = 0; s < BOARD_W; s++) begin
         if (i_src[s] && step_legal(IDX_W'(s), DIR))
            o_dst[step_dst(IDX_W'(s), DIR)] = 1'b1;
      end
   end
endmodule

// File: rtl/checkers_move_enum.sv
// Serial legal-move enumerator for one checkers position, one move per valid/ready handshake.
// Define MOVE_ENUM_JUMPS_EN to add a forced-capture single-jump phase ahead of simple moves.
module checkers_move_enum
   import checkers_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               side,
   input  logic [BOARD_W-1:0] own,
   input  logic [BOARD_W-1:0] opp,
   input  logic [BOARD_W-1:0] kings,
   input  logic               move_ready,
   output logic               move_valid,
   output logic [IDX_W-1:0]   move_from,
   output logic [IDX_W-1:0]   move_to,
   output logic [1:0]         move_dir,
   output logic               move_jump,
   output logic               busy,
   output logic               done,
   output logic [CNT_W-1:0]   move_count,
   output logic               no_moves
);
`ifdef MOVE_ENUM_JUMPS_EN
   localparam bit JUMPS_EN = 1'b1;
`else
   localparam bit JUMPS_EN = 1'b0;
`endif

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == CNT_W'(MAX_MOVES)) ? c : c + CNT_W'(1);
   endfunction

   state_t             r_state, w_state_nxt;
   dir_t               r_dir;
   logic               r_jphase, r_jumped, r_side;
   logic [CNT_W-1:0]   r_count;
   logic [BOARD_W-1:0] r_own, r_opp, r_kings;
   logic [BOARD_W-1:0] r_mask [4];
   logic [BOARD_W-1:0] r_jmask [4];
   logic [BOARD_W-1:0] r_jtmp [4];
   logic [BOARD_W-1:0] w_shift_in [4];
   logic [BOARD_W-1:0] w_shift_out [4];
   logic [BOARD_W-1:0] w_empty, w_men, w_cur;
   logic               w_any, w_take;
   logic [IDX_W-1:0]   w_to, w_from;

   assign w_empty = ~(r_own | r_opp);
   assign w_men   = r_own & ~r_kings;

   // Kings move every way; men only forward. The second CALC cycle reuses the shifters on the
   // opponent-adjacent squares to find jump landings.
   always_comb begin
      for (int d = 0; d < 4; d++) begin
         w_shift_in[d] = r_own & r_kings;
         if ((d < 2) != r_side) w_shift_in[d] = w_shift_in[d] | w_men;
         if (r_state == ST_CALC2) w_shift_in[d] = r_jtmp[d];
      end
   end

   for (genvar gd = 0; gd < 4; gd++) begin : g_shift
      board_diag_shift #(.DIR(dir_t'(gd))) u_shift (
         .i_src (w_shift_in[gd]),
         .o_dst (w_shift_out[gd])
      );
   end

   assign w_cur  = r_jphase ? r_jmask[r_dir] : r_mask[r_dir];
   assign w_any  = (r_state == ST_EMIT) && (|w_cur);
   assign w_take = w_any && move_ready;

   always_comb begin
      w_to = '0;
      for (int i = BOARD_W - 1; i >= 0; i--)
         if (w_cur[i]) w_to = IDX_W'(i);
   end

   assign w_from = r_jphase ? step_src(step_src(w_to, r_dir), r_dir) : step_src(w_to, r_dir);

   always_ff @(posedge clock) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      move_valid  = w_any;
      move_from   = '0;
      move_to     = '0;
      move_dir    = '0;
      move_jump   = 1'b0;
      case (r_state)
         ST_IDLE:  if (start) w_state_nxt = ST_CALC;
         ST_CALC:  w_state_nxt = JUMPS_EN ? ST_CALC2 : ST_EMIT;
         ST_CALC2: w_state_nxt = ST_EMIT;
         ST_EMIT:  if (!w_any && r_dir == DIR_UL && !(r_jphase && !r_jumped))
                      w_state_nxt = ST_DONE;
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
      if (w_any) begin
         move_from = w_from;
         move_to   = w_to;
         move_dir  = r_dir;
         move_jump = r_jphase;
      end
      busy     = (r_state != ST_IDLE);
      done     = (r_state == ST_DONE);
      no_moves = done && (r_count == '0);
   end

   assign move_count = r_count;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_dir    <= DIR_DR;
         r_jphase <= 1'b0;
         r_jumped <= 1'b0;
         r_count  <= '0;
      end else begin
         case (r_state)
            ST_CALC: begin
               r_dir    <= DIR_DR;
               r_jphase <= JUMPS_EN;
               r_jumped <= 1'b0;
               r_count  <= '0;
            end
            ST_EMIT: begin
               if (w_take) begin
                  r_count <= sat_inc(r_count);
                  if (r_jphase) r_jumped <= 1'b1;
               end else if (!w_any) begin
                  if (r_dir != DIR_UL) begin
                     r_dir <= dir_t'(r_dir + 2'd1);
                  end else if (r_jphase && !r_jumped) begin
                     r_jphase <= 1'b0;
                     r_dir    <= DIR_DR;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Board and target-mask datapath; an accepted move retires its destination bit.
   always_ff @(posedge clock) begin
      if (r_state == ST_IDLE && start) begin
         r_own   <= own;
         r_opp   <= opp;
         r_kings <= kings;
         r_side  <= side;
      end
      for (int d = 0; d < 4; d++) begin
         if (r_state == ST_CALC) begin
            r_mask[d] <= w_shift_out[d] & w_empty;
            r_jtmp[d] <= w_shift_out[d] & r_opp;
         end
         if (r_state == ST_CALC2) r_jmask[d] <= w_shift_out[d] & w_empty;
      end
      if (w_take) begin
         if (r_jphase) r_jmask[r_dir][w_to] <= 1'b0;
         else          r_mask[r_dir][w_to]  <= 1'b0;
      end
   end
endmodule
